// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer: FSM states, the NOP
// instruction word and the control-flow target helpers.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_PENDING,
    ST_SQUASH
  } seq_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned SQUASH_W = 3;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] imm);
    return {pc4[31:28], imm, 2'b00};
  endfunction

  function automatic logic [31:0] beq_target(input logic [31:0] pc4,
                                             input logic [31:0] imm);
    return pc4 + {imm[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_redirect_target.sv
// Combinational redirect detection and target selection for jump/beq in ID.
import pc_sequencer_pkg::*;

module redirect_target (
  input  logic        flag_jump,
  input  logic [25:0] jump_imme,
  input  logic        flag_beq,
  input  logic [31:0] beq_imme,
  input  logic [31:0] id_pc4,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = flag_jump | flag_beq;
    // Jump wins when both flags are raised in the same cycle.
    if (flag_jump) target = jump_target(id_pc4, jump_imme);
    else           target = beq_target(id_pc4, beq_imme);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequences the PC around redirects, load-use stalls and
// instruction-memory wait states, and counts accepted redirects.
import pc_sequencer_pkg::*;

module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FLUSH_SLOTS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req,
  input  logic        imem_ready,
  input  logic        flag_jump,
  input  logic [25:0] jump_imme,
  input  logic        flag_beq,
  input  logic [31:0] beq_imme,
  input  logic [31:0] id_pc4,
  output logic [31:0] pc,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic [15:0] redirect_count
);

  localparam seq_state_e          AFTER_LOAD  = (FLUSH_SLOTS > 1) ? ST_SQUASH : ST_RUN;
  localparam logic [SQUASH_W-1:0] SQUASH_INIT = SQUASH_W'(FLUSH_SLOTS - 1);

  seq_state_e          state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         tgt_q, tgt_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [SQUASH_W-1:0] sq_q, sq_d;

  logic        redirect;
  logic [31:0] target;

  redirect_target u_redirect_target (
    .flag_jump (flag_jump),
    .jump_imme (jump_imme),
    .flag_beq  (flag_beq),
    .beq_imme  (beq_imme),
    .id_pc4    (id_pc4),
    .redirect  (redirect),
    .target    (target)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
    sq_d         = sq_q;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    unique case (state_q)
      // STALL shares RUN's rules: once stall_req drops, flags are acted on at once.
      ST_RUN, ST_STALL: begin
        if (stall_req) begin
          state_d      = ST_STALL;
          id_ex_bubble = 1'b1;
        end else if (redirect) begin
          if_id_flush = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          if (imem_ready) begin
            pc_d    = target;
            sq_d    = SQUASH_INIT;
            state_d = AFTER_LOAD;
          end else begin
            tgt_d   = target;
            state_d = ST_PENDING;
          end
        end else begin
          state_d = ST_RUN;
          if (imem_ready) begin
            pc_d        = pc_q + 32'd4;
            if_id_write = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if_id_flush = 1'b1;
        if (imem_ready) begin
          pc_d    = tgt_q;
          sq_d    = SQUASH_INIT;
          state_d = AFTER_LOAD;
        end
      end
      ST_SQUASH: begin
        if (imem_ready) begin
          if_id_flush = 1'b1;
          pc_d        = pc_q + 32'd4;
          sq_d        = sq_q - SQUASH_W'(1);
          if (sq_q <= SQUASH_W'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (rst) begin
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      tgt_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[31:2], 2'b00};
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
    end
  end

  assign pc             = pc_q;
  assign redirect_count = cnt_q;

endmodule
